// File: rtl/svc_uart_rx.sv
// rtl/svc_uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a single-entry valid/ready output register
module svc_uart_rx #(
  parameter int CLOCK_FREQ = 1_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx_pin,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       urx_frame_err,
  output logic       urx_overrun
);

  // Rounded clocks per bit; the start bit is re-checked half a bit after the falling edge.
  localparam int CLKS_PER_BIT = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_s;
  logic             deliver;

  assign rx_s = sync2_q;

  // Two-flop synchronizer; both stages idle high so reset does not look like a start bit.
  always_comb begin
    sync1_d = urx_pin;
    sync2_d = sync1_q;
  end

  // Receive FSM: start qualification, LSB-first data sampling, stop check and break hold-off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d = S_DATA;
          cnt_d   = CNT_BIT;
          idx_d   = 3'd0;
        end else begin
          // Line went back high before mid-start: treat as a glitch.
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = CNT_BIT;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          deliver = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        // A held-low line must return high before another start is recognised.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output register: load on delivery when empty or being drained, otherwise flag an overrun.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (deliver) begin
      if (!valid_q || urx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && urx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign urx_valid     = valid_q;
  assign urx_data      = data_q;
  assign urx_frame_err = frame_err_q;
  assign urx_overrun   = overrun_q;

endmodule
